// File: rtl/pwm_regs_multi.sv
// Multi-channel PWM register bank: atomic 16-bit writes via a staging byte, shadow/active
// buffers committed at period boundaries, coherent counter readback and W1C interrupts.
module pwm_regs_multi #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RST_PULSE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   read,
  input  logic                   write,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [7:0]             data_write,
  output logic [7:0]             data_read,
  input  logic [15:0]            counter_val,
  input  logic                   period_evt,
  output logic [15:0]            period,
  output logic                   en,
  output logic                   count_reset,
  output logic                   upnotdown,
  output logic [7:0]             prescale,
  output logic [NUM_CH-1:0]      pwm_en,
  output logic [2*NUM_CH-1:0]    functions,
  output logic [16*NUM_CH-1:0]   compare1,
  output logic [16*NUM_CH-1:0]   compare2,
  output logic                   irq
);

  localparam int unsigned BlkW     = ADDR_W - 4;
  localparam logic [3:0]  NumChNib = 4'(NUM_CH);
  localparam logic [3:0]  RstPulse = 4'(RST_PULSE);

  logic                   r_en, r_upnotdown, r_pending, r_irq;
  logic [7:0]             r_prescale, r_staging, r_snapshot;
  logic [15:0]            r_period_sh, r_period_act;
  logic [NUM_CH-1:0][15:0] r_cmp1_sh, r_cmp1_act, r_cmp2_sh, r_cmp2_act;
  logic [NUM_CH-1:0]      r_pwm_en;
  logic [NUM_CH-1:0][1:0] r_functions;
  logic [2:0]             r_irq_status, r_irq_en;
  logic [3:0]             r_rst_cnt;

  logic                   w_en_nxt, w_upnotdown_nxt, w_pending_nxt;
  logic [7:0]             w_prescale_nxt, w_staging_nxt, w_snapshot_nxt;
  logic [15:0]            w_period_sh_nxt, w_period_act_nxt;
  logic [NUM_CH-1:0][15:0] w_cmp1_sh_nxt, w_cmp1_act_nxt, w_cmp2_sh_nxt, w_cmp2_act_nxt;
  logic [NUM_CH-1:0]      w_pwm_en_nxt;
  logic [NUM_CH-1:0][1:0] w_functions_nxt;
  logic [2:0]             w_irq_status_nxt, w_irq_en_nxt, w_irq_clr;
  logic [3:0]             w_rst_cnt_nxt;

  logic [3:0]             w_off;
  logic [BlkW-1:0]        w_blk;
  logic                   w_glob, w_mapped, w_ro, w_wr, w_err, w_xfer;
  logic [NUM_CH-1:0]      w_ch_sel;

  // Address decode: block 0 is the global map, block n+1 is channel n.
  assign w_off  = addr[3:0];
  assign w_blk  = addr[ADDR_W-1:4];
  assign w_glob = (w_blk == '0);

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      w_ch_sel[n] = (w_blk == BlkW'(n + 1)) && (w_off <= 4'h4);
    end
  end

  always_comb begin
    w_mapped = |w_ch_sel;
    w_ro     = 1'b0;
    if (w_glob) begin
      w_mapped = (w_off <= 4'h9);
      w_ro     = (w_off == 4'h5) || (w_off == 4'h6) || (w_off == 4'h9);
    end
  end

  assign w_wr   = write && w_mapped && !w_ro;
  assign w_err  = (write && !(w_mapped && !w_ro)) || (read && !w_mapped);
  assign w_xfer = r_pending && (period_evt || !r_en || count_reset);

  always_comb begin
    data_read = 8'h00;
    if (read && w_mapped) begin
      if (w_glob) begin
        case (w_off)
          4'h0:    data_read = {6'd0, r_upnotdown, r_en};
          4'h1:    data_read = r_prescale;
          4'h2:    data_read = r_period_sh[7:0];
          4'h3:    data_read = r_period_sh[15:8];
          4'h5:    data_read = counter_val[7:0];
          4'h6:    data_read = r_snapshot;
          4'h7:    data_read = {5'd0, r_irq_status};
          4'h8:    data_read = {5'd0, r_irq_en};
          4'h9:    data_read = {4'h2, NumChNib};
          default: data_read = 8'h00;
        endcase
      end else begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (w_ch_sel[n]) begin
            case (w_off)
              4'h0:    data_read = {5'd0, r_functions[n], r_pwm_en[n]};
              4'h1:    data_read = r_cmp1_sh[n][7:0];
              4'h2:    data_read = r_cmp1_sh[n][15:8];
              4'h3:    data_read = r_cmp2_sh[n][7:0];
              4'h4:    data_read = r_cmp2_sh[n][15:8];
              default: data_read = 8'h00;
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    w_en_nxt         = r_en;
    w_upnotdown_nxt  = r_upnotdown;
    w_pending_nxt    = r_pending;
    w_prescale_nxt   = r_prescale;
    w_staging_nxt    = r_staging;
    w_snapshot_nxt   = r_snapshot;
    w_period_sh_nxt  = r_period_sh;
    w_period_act_nxt = r_period_act;
    w_cmp1_sh_nxt    = r_cmp1_sh;
    w_cmp1_act_nxt   = r_cmp1_act;
    w_cmp2_sh_nxt    = r_cmp2_sh;
    w_cmp2_act_nxt   = r_cmp2_act;
    w_pwm_en_nxt     = r_pwm_en;
    w_functions_nxt  = r_functions;
    w_irq_en_nxt     = r_irq_en;
    w_rst_cnt_nxt    = (r_rst_cnt != 4'd0) ? r_rst_cnt - 4'd1 : 4'd0;
    w_irq_clr        = 3'b000;

    // Commit takes the registered shadow, so a coincident H write stays pending.
    if (w_xfer) begin
      w_period_act_nxt = r_period_sh;
      w_cmp1_act_nxt   = r_cmp1_sh;
      w_cmp2_act_nxt   = r_cmp2_sh;
      w_pending_nxt    = 1'b0;
    end

    if (read && w_glob && (w_off == 4'h5)) begin
      w_snapshot_nxt = counter_val[15:8];
    end

    if (w_wr) begin
      if (w_glob) begin
        case (w_off)
          4'h0: begin
            w_en_nxt        = data_write[0];
            w_upnotdown_nxt = data_write[1];
          end
          4'h1: w_prescale_nxt = data_write;
          4'h2: w_staging_nxt  = data_write;
          4'h3: begin
            w_period_sh_nxt = {data_write, r_staging};
            w_pending_nxt   = 1'b1;
          end
          4'h4: w_rst_cnt_nxt = RstPulse;
          4'h7: w_irq_clr     = data_write[2:0];
          4'h8: w_irq_en_nxt  = data_write[2:0];
          default: ;
        endcase
      end else begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (w_ch_sel[n]) begin
            case (w_off)
              4'h0: begin
                w_pwm_en_nxt[n]    = data_write[0];
                w_functions_nxt[n] = data_write[2:1];
              end
              4'h1, 4'h3: w_staging_nxt = data_write;
              4'h2: begin
                w_cmp1_sh_nxt[n] = {data_write, r_staging};
                w_pending_nxt    = 1'b1;
              end
              4'h4: begin
                w_cmp2_sh_nxt[n] = {data_write, r_staging};
                w_pending_nxt    = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    end

    // Set has priority over a same-cycle W1C clear.
    w_irq_status_nxt = (r_irq_status & ~w_irq_clr) | {w_err, w_xfer, period_evt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en         <= 1'b0;
      r_upnotdown  <= 1'b1;
      r_pending    <= 1'b0;
      r_prescale   <= 8'h00;
      r_staging    <= 8'h00;
      r_snapshot   <= 8'h00;
      r_period_sh  <= 16'h0000;
      r_period_act <= 16'h0000;
      r_cmp1_sh    <= '0;
      r_cmp1_act   <= '0;
      r_cmp2_sh    <= '0;
      r_cmp2_act   <= '0;
      r_pwm_en     <= '0;
      r_functions  <= '0;
      r_irq_status <= 3'b000;
      r_irq_en     <= 3'b000;
      r_rst_cnt    <= 4'd0;
      r_irq        <= 1'b0;
    end else begin
      r_en         <= w_en_nxt;
      r_upnotdown  <= w_upnotdown_nxt;
      r_pending    <= w_pending_nxt;
      r_prescale   <= w_prescale_nxt;
      r_staging    <= w_staging_nxt;
      r_snapshot   <= w_snapshot_nxt;
      r_period_sh  <= w_period_sh_nxt;
      r_period_act <= w_period_act_nxt;
      r_cmp1_sh    <= w_cmp1_sh_nxt;
      r_cmp1_act   <= w_cmp1_act_nxt;
      r_cmp2_sh    <= w_cmp2_sh_nxt;
      r_cmp2_act   <= w_cmp2_act_nxt;
      r_pwm_en     <= w_pwm_en_nxt;
      r_functions  <= w_functions_nxt;
      r_irq_status <= w_irq_status_nxt;
      r_irq_en     <= w_irq_en_nxt;
      r_rst_cnt    <= w_rst_cnt_nxt;
      r_irq        <= |(w_irq_status_nxt & w_irq_en_nxt);
    end
  end

  assign period      = r_period_act;
  assign en          = r_en;
  assign count_reset = (r_rst_cnt != 4'd0);
  assign upnotdown   = r_upnotdown;
  assign prescale    = r_prescale;
  assign pwm_en      = r_pwm_en;
  assign functions   = r_functions;
  assign compare1    = r_cmp1_act;
  assign compare2    = r_cmp2_act;
  assign irq         = r_irq;

endmodule

// File: doc/pwm_regs_multi.md
Name: pwm_regs_multi

Overview:
Parametrised multi-channel register bank for the PWM generator. It replaces the single-channel register file and serves NUM_CH PWM channels that share one counter. It adds atomic 16-bit writes through a staging byte, shadow/active double buffering committed at period boundaries, a coherent 16-bit counter readback, and a sticky W1C interrupt block. It sits between the SPI/bus decoder and the counter plus the per-channel PWM generators.

Parameters:
NUM_CH, 4, number of PWM channels (legal 1..8)
ADDR_W, 8, decoder address width (legal values must hold 0x10+NUM_CH*0x10-1)
RST_PULSE, 2, width of count_reset pulse in clk cycles (legal 1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
read  in  1  read strobe, single cycle
write  in  1  write strobe, single cycle
addr  in  ADDR_W  register address
data_write  in  8  write data
data_read  out  8  read data, combinational; 0 when read=0
counter_val  in  16  live counter value
period_evt  in  1  one-cycle pulse from the counter at wrap/underflow
period  out  16  active period
en  out  1  counter enable
count_reset  out  1  counter reset pulse
upnotdown  out  1  count direction
prescale  out  8  prescaler
pwm_en  out  NUM_CH  per-channel enable
functions  out  2*NUM_CH  per-channel mode; channel n uses bits [2n+1:2n]
compare1  out  16*NUM_CH  active compare1; channel n uses bits [16n+15:16n]
compare2  out  16*NUM_CH  active compare2, same packing
irq  out  1  |(irq_status & irq_en), registered

Behaviour:
- Global map:
  - 0x00 CTRL rw: b0=en, b1=upnotdown
  - 0x01 PRESCALE rw
  - 0x02 PERIOD_L rw
  - 0x03 PERIOD_H rw
  - 0x04 COUNTER_RESET wo
  - 0x05 CNT_L ro
  - 0x06 CNT_H ro
  - 0x07 IRQ_STATUS rw1c: b0 wrap, b1 update-applied, b2 access-error
  - 0x08 IRQ_EN rw, bits 2:0
  - 0x09 INFO ro = {4'h2, NUM_CH[3:0]}
- Channel n base is 0x10+0x10*n:
  - +0 CH_CTRL rw: b0=pwm_en, b2:1=functions
  - +1 CMP1_L, +2 CMP1_H, +3 CMP2_L, +4 CMP2_H, all rw
- Reset values:
  - period, prescale, compares (shadow and active), staging, snapshot, irq_status, irq_en, pwm_en, functions, en, pending: 0
  - upnotdown: 1; count_reset: 0; irq: 0
- Atomic 16-bit writes:
  - A *_L write stores data in the shared 8-bit staging register only.
  - A *_H write loads shadow = {data_write, staging} in the same cycle and sets pending.
  - An L write without a following H write leaves the shadow unchanged.
  - Reading *_L/*_H returns the shadow bytes.
- Double buffering covers period, compare1 and compare2 only. CTRL, PRESCALE, CH_CTRL and IRQ_EN take effect on the next clk edge.
- Transfer: when pending && (period_evt || !en || count_reset), then on that edge all active <= shadow, pending <= 0, and irq_status.b1 is set.
  - With en=0, outputs update 2 cycles after the H write.
- Simultaneous H write and transfer: the transfer uses the pre-write shadow. pending stays 1, so the new value transfers at the next boundary.
- Counter snapshot:
  - A read of CNT_L returns counter_val[7:0] and latches counter_val[15:8] into the snapshot.
  - A read of CNT_H returns the snapshot.
- count_reset:
  - A write to 0x04 asserts count_reset for RST_PULSE cycles, starting the next cycle.
  - A rewrite during the pulse restarts the full count.
- irq_status:
  - b0 is set on period_evt.
  - b2 is set on a write to a ro/unmapped address, or a read of an unmapped address; such accesses have no other effect and reads return 0.
  - Writing 1 clears a bit. If a set and a clear hit the same cycle, set wins.
- Channel-block addresses for n>=NUM_CH and unused offsets +5..+F are unmapped.
- read and write both high in one cycle: the write is executed, and data_read reflects pre-write state.
- rst_n low mid-operation returns all state to reset values immediately, including aborting a count_reset pulse.

Test Plan:
- Reset, then read all mapped addresses -> CTRL=0x02, INFO=0x24 (NUM_CH=4), all others 0x00; irq=0.
- en=0: write CMP1_L(ch2)=0x34, CMP1_H(ch2)=0x12 -> compare1[47:32]=0x1234 two cycles after the H write, irq_status=0x02; an L-only write of 0x99 leaves the read value at 0x1234.
- en=1, period=100: write PERIOD=0x00C8 -> period output stays 100 until period_evt, then 0x00C8 on the next edge; H write coincident with period_evt -> transfer delayed to the following period_evt.
- counter_val=0xABCD: read CNT_L -> 0xCD; counter_val changes to 0x0001, read CNT_H -> 0xAB.
- RST_PULSE=2: write 0x04, then rewrite 1 cycle later -> count_reset high for 3 consecutive cycles total.
- irq_en=0x01: period_evt -> irq=1; write IRQ_STATUS=0x01 in the same cycle as a new period_evt -> bit stays set; write to 0x05 -> b2 set, register unchanged.
